led_display_scheduler: RTL

- Sequencer and arbiter for the front-panel LED bank on CFG_DAT.
- Steps the startup animation through the pattern table and strobes the PWM pattern datapath to load each entry.
- Counts dwell time from a 1 us tick and counts table passes.
- Arbitrates the 16-bit LED output between three sources: status (default), animation, and host override (highest priority).

---
 rtl/led_display_scheduler.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/led_display_scheduler.sv
// Front-panel LED sequencer: steps the startup animation through the pattern table
// and arbitrates the LED word between status, animation and host override.
module led_display_scheduler #(
    parameter int NPAT  = 32,
    parameter int AW    = 5,
    parameter int NPASS = 3
) (
    input  logic          CLK,
    input  logic          rst_timer,
    input  logic          TICK,
    input  logic          RUN,
    input  logic [15:0]   DWELL,
    input  logic [15:0]   PAT_ON,
    input  logic [15:0]   STATUS,
    input  logic          OVR_REQ,
    input  logic [15:0]   OVR_PAT,
    output logic [AW-1:0] RADDR,
    output logic          LOAD_PAT,
    output logic [15:0]   LED_OUT,
    output logic [1:0]    SRC,
    output logic          BUSY,
    output logic          DONE
);

    localparam int              PW        = $clog2(NPASS + 1);
    localparam logic [AW-1:0]   ADDR_LAST = AW'(NPAT - 1);
    localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
    localparam logic [PW-1:0]   PASS_LAST = PW'(NPASS - 1);
    localparam logic [PW-1:0]   PASS_ONE  = PW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHOW   = 3'd2,
        S_NEXT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SRC_STATUS = 2'd0,
        SRC_ANIM   = 2'd1,
        SRC_OVR    = 2'd2
    } src_t;

    state_t          state, state_d;
    logic [AW-1:0]   raddr_q, raddr_d;
    logic [PW-1:0]   passes, passes_d;
    logic [15:0]     timer, timer_d, timer_inc;
    logic [15:0]     dwell_lim, dwell_lim_d;
    logic            load_pat;
    logic            active;
    logic [15:0]     led_p1;
    src_t            src_p1;

    assign active    = (state == S_LOAD) || (state == S_SHOW) || (state == S_NEXT);
    assign timer_inc = timer + 16'd1;

    // RUN=0 outranks the override freeze; the freeze outranks every other transition.
    always_comb begin
        state_d     = state;
        raddr_d     = raddr_q;
        passes_d    = passes;
        timer_d     = timer;
        dwell_lim_d = dwell_lim;
        load_pat    = 1'b0;
        if (!RUN) begin
            state_d  = S_IDLE;
            raddr_d  = '0;
            passes_d = '0;
            timer_d  = '0;
        end else if (!OVR_REQ) begin
            case (state)
                S_IDLE: begin
                    raddr_d  = '0;
                    passes_d = '0;
                    timer_d  = '0;
                    state_d  = S_LOAD;
                end
                S_LOAD: begin
                    load_pat    = 1'b1;
                    timer_d     = '0;
                    dwell_lim_d = (DWELL == 16'd0) ? 16'd1 : DWELL;
                    state_d     = S_SHOW;
                end
                S_SHOW: begin
                    if (TICK) begin
                        timer_d = timer_inc;
                        if (timer_inc == dwell_lim) begin
                            state_d = S_NEXT;
                        end
                    end
                end
                S_NEXT: begin
                    if (raddr_q == ADDR_LAST) begin
                        raddr_d = '0;
                        if (passes == PASS_LAST) begin
                            passes_d = '0;
                            state_d  = S_FINISH;
                        end else begin
                            passes_d = passes + PASS_ONE;
                            state_d  = S_LOAD;
                        end
                    end else begin
                        raddr_d = raddr_q + ADDR_ONE;
                        state_d = S_LOAD;
                    end
                end
                S_FINISH: begin
                    raddr_d  = '0;
                    passes_d = '0;
                end
                default: begin
                    state_d  = S_IDLE;
                    raddr_d  = '0;
                    passes_d = '0;
                    timer_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge rst_timer) begin
        if (rst_timer) begin
            state     <= S_IDLE;
            raddr_q   <= '0;
            passes    <= '0;
            timer     <= '0;
            dwell_lim <= 16'd1;
        end else begin
            state     <= state_d;
            raddr_q   <= raddr_d;
            passes    <= passes_d;
            timer     <= timer_d;
            dwell_lim <= dwell_lim_d;
        end
    end

    // Output stage p1: source select registered one cycle after the inputs.
    always_ff @(posedge CLK or posedge rst_timer) begin
        if (rst_timer) begin
            led_p1 <= '0;
            src_p1 <= SRC_STATUS;
        end else if (OVR_REQ) begin
            led_p1 <= OVR_PAT;
            src_p1 <= SRC_OVR;
        end else if (active) begin
            led_p1 <= PAT_ON;
            src_p1 <= SRC_ANIM;
        end else begin
            led_p1 <= STATUS;
            src_p1 <= SRC_STATUS;
        end
    end

    assign RADDR    = raddr_q;
    assign LOAD_PAT = load_pat;
    assign LED_OUT  = led_p1;
    assign SRC      = src_p1;
    assign BUSY     = active;
    assign DONE     = (state == S_FINISH);

endmodule
